// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: decode-side RAW hazard unit for the in-order core.
// Shift-register scoreboard of in-flight writes, stall/flush control, and
// a three-state control FSM (RUN / STALL / FLUSH).
//
// Optional feature macro: FORWARD_EN
//   defined   -> youngest-match forwarding selects, stall only on load-use
//                or on matches too old to forward
//   undefined -> any scoreboard match stalls; fwd_sel_* tied to zero
//
// Ports:
//   clk          rising-edge clock for all state
//   reset        synchronous, active-high
//   id_rd_en     decode source enables {rs2, rs1}
//   id_rs1/2     decode source indices
//   id_we/id_rd  decode destination write enable / index
//   id_is_load   decode instruction is a load
//   jumping      control transfer resolved in E this cycle
//   stall_F      hold PC
//   stall_D      hold F/D register
//   flush_D      kill F/D contents
//   flush_E      bubble into D/E register
//   busy_mask    per-register "write in flight" bits (bit 0 always 0)
//   fsm_state    00 RUN, 01 STALL, 10 FLUSH
//   stall_count  saturating count of stall_D cycles
//   fwd_sel_rs1/2 forwarding selects (0 = register file, k+1 = entry k)

module hazard_scoreboard #(
    parameter int NUM_REGS     = 32,
    parameter int REG_AW       = 5,
    parameter int PIPE_DEPTH   = 3,
    parameter int WB_BYPASS    = 1,
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [1:0]          id_rd_en,
    input  logic [REG_AW-1:0]   id_rs1,
    input  logic [REG_AW-1:0]   id_rs2,
    input  logic                id_we,
    input  logic [REG_AW-1:0]   id_rd,
    input  logic                id_is_load,
    input  logic                jumping,
    output logic                stall_F,
    output logic                stall_D,
    output logic                flush_D,
    output logic                flush_E,
    output logic [NUM_REGS-1:0] busy_mask,
    output logic [1:0]          fsm_state,
    output logic [CNT_W-1:0]    stall_count,
    output logic [1:0]          fwd_sel_rs1,
    output logic [1:0]          fwd_sel_rs2
);

    localparam logic [1:0] S_RUN   = 2'b00;
    localparam logic [1:0] S_STALL = 2'b01;
    localparam logic [1:0] S_FLUSH = 2'b10;

    // Entries below HZ_LIM can collide; the WB entry is excluded when the
    // register file writes before it reads.
    localparam int HZ_LIM = (WB_BYPASS != 0) ? PIPE_DEPTH - 1 : PIPE_DEPTH;

    // Counter holds the number of FLUSH-state cycles still to follow.
    localparam int FCNT_W = (FLUSH_CYCLES > 2) ? $clog2(FLUSH_CYCLES - 1) : 1;
    localparam logic [FCNT_W-1:0] FCNT_LOAD =
        FCNT_W'((FLUSH_CYCLES > 1) ? FLUSH_CYCLES - 2 : 0);

    // Scoreboard entries {valid, rd, load}; entry 0 = E stage
    logic [PIPE_DEPTH-1:0] r_vld;
    logic [PIPE_DEPTH-1:0] r_ld;
    logic [REG_AW-1:0]     r_rd [PIPE_DEPTH];

    logic [1:0]            r_state;
    logic [FCNT_W-1:0]     r_fcnt;
    logic [CNT_W-1:0]      r_stall_cnt;

    logic [1:0]            w_state_nxt;
    logic [FCNT_W-1:0]     w_fcnt_nxt;
    logic [PIPE_DEPTH-1:0] w_m1;
    logic [PIPE_DEPTH-1:0] w_m2;
    logic                  w_block;
    logic                  w_raw;
    logic                  w_hazard;
    logic                  w_load;
    logic [NUM_REGS-1:0]   w_busy;

    // ---------------- source / entry matching ----------------
    always_comb begin
        w_m1 = '0;
        w_m2 = '0;
        for (int k = 0; k < PIPE_DEPTH; k++) begin
            if (k < HZ_LIM) begin
                w_m1[k] = id_rd_en[0] && (id_rs1 != '0) &&
                          r_vld[k] && (r_rd[k] == id_rs1);
                w_m2[k] = id_rd_en[1] && (id_rs2 != '0) &&
                          r_vld[k] && (r_rd[k] == id_rs2);
            end
        end
    end

`ifdef FORWARD_EN
    logic [1:0] w_sel1;
    logic [1:0] w_sel2;
    logic       w_lu1;
    logic       w_lu2;
    logic       w_deep;

    // Descending scan so the youngest (lowest k) match is the one kept.
    always_comb begin
        w_sel1 = 2'd0;
        w_sel2 = 2'd0;
        w_lu1  = 1'b0;
        w_lu2  = 1'b0;
        w_deep = 1'b0;
        for (int k = PIPE_DEPTH - 1; k >= 0; k--) begin
            if (w_m1[k]) begin
                w_sel1 = (k < 3) ? 2'(k + 1) : 2'd0;
                w_lu1  = (k == 0) && r_ld[0];
            end
            if (w_m2[k]) begin
                w_sel2 = (k < 3) ? 2'(k + 1) : 2'd0;
                w_lu2  = (k == 0) && r_ld[0];
            end
            // Only three forwarding paths exist; older matches must stall.
            if (k >= 3) begin
                w_deep = w_deep | w_m1[k] | w_m2[k];
            end
        end
    end

    assign w_raw       = w_lu1 | w_lu2 | w_deep;
    assign fwd_sel_rs1 = w_sel1;
    assign fwd_sel_rs2 = w_sel2;
`else
    logic w_unused_ld;

    // Load tag is carried in the entries but only consumed by forwarding.
    assign w_unused_ld = ^r_ld;
    assign w_raw       = (|w_m1) | (|w_m2);
    assign fwd_sel_rs1 = 2'd0;
    assign fwd_sel_rs2 = 2'd0;
`endif

    // A jump (or an ongoing flush) kills decode, so it can never stall.
    assign w_block  = jumping || (r_state == S_FLUSH);
    assign w_hazard = w_raw && !w_block;
    assign w_load   = id_we && (id_rd != '0) && !w_hazard && !w_block;

    // ---------------- scoreboard shift ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_vld <= '0;
            r_ld  <= '0;
            for (int k = 0; k < PIPE_DEPTH; k++) begin
                r_rd[k] <= '0;
            end
        end else begin
            for (int k = PIPE_DEPTH - 1; k > 0; k--) begin
                r_vld[k] <= r_vld[k-1];
                r_ld[k]  <= r_ld[k-1];
                r_rd[k]  <= r_rd[k-1];
            end
            r_vld[0] <= w_load;
            r_ld[0]  <= w_load && id_is_load;
            r_rd[0]  <= id_rd;
        end
    end

    // ---------------- busy mask ----------------
    always_comb begin
        w_busy = '0;
        for (int k = 0; k < PIPE_DEPTH; k++) begin
            if (r_vld[k]) begin
                w_busy[r_rd[k]] = 1'b1;
            end
        end
        w_busy[0] = 1'b0;
    end

    assign busy_mask = w_busy;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_RUN;
            r_fcnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_fcnt  <= w_fcnt_nxt;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_nxt = r_state;
        w_fcnt_nxt  = r_fcnt;
        case (r_state)
            S_FLUSH: begin
                if (jumping) begin
                    w_fcnt_nxt = FCNT_LOAD;
                end else if (r_fcnt == '0) begin
                    w_state_nxt = S_RUN;
                end else begin
                    w_fcnt_nxt = r_fcnt - FCNT_W'(1);
                end
            end
            default: begin
                if (jumping && (FLUSH_CYCLES > 1)) begin
                    w_state_nxt = S_FLUSH;
                    w_fcnt_nxt  = FCNT_LOAD;
                end else if (w_hazard) begin
                    w_state_nxt = S_STALL;
                end else begin
                    w_state_nxt = S_RUN;
                end
            end
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        stall_F   = w_hazard;
        stall_D   = w_hazard;
        flush_E   = w_hazard;
        flush_D   = w_block;
        fsm_state = r_state;
    end

    // ---------------- stall counter ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt <= '0;
        end else if (w_hazard && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign stall_count = r_stall_cnt;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed scenarios plus randomized traffic checked
// against a queue-based model of in-flight writes.

module tb_hazard_scoreboard;

    localparam int NR  = 32;
    localparam int AW  = 5;
    localparam int PD  = 3;
    localparam int WBB = 1;
    localparam int FC  = 3;
    localparam int CW  = 16;
    localparam int LIM = (WBB != 0) ? PD - 1 : PD;

    logic          clk = 1'b0;
    logic          reset;
    logic [1:0]    id_rd_en;
    logic [AW-1:0] id_rs1, id_rs2, id_rd;
    logic          id_we, id_is_load, jumping;
    logic          stall_F, stall_D, flush_D, flush_E;
    logic [NR-1:0] busy_mask;
    logic [1:0]    fsm_state;
    logic [CW-1:0] stall_count;
    logic [1:0]    fwd_sel_rs1, fwd_sel_rs2;

    always #5 clk = ~clk;

    hazard_scoreboard #(
        .NUM_REGS(NR), .REG_AW(AW), .PIPE_DEPTH(PD),
        .WB_BYPASS(WBB), .FLUSH_CYCLES(FC), .CNT_W(CW)
    ) dut (
        .clk(clk), .reset(reset),
        .id_rd_en(id_rd_en), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_we(id_we), .id_rd(id_rd), .id_is_load(id_is_load),
        .jumping(jumping),
        .stall_F(stall_F), .stall_D(stall_D),
        .flush_D(flush_D), .flush_E(flush_E),
        .busy_mask(busy_mask), .fsm_state(fsm_state),
        .stall_count(stall_count),
        .fwd_sel_rs1(fwd_sel_rs1), .fwd_sel_rs2(fwd_sel_rs2)
    );

    // ---------------- reference model ----------------
    typedef struct {
        int rd;
        int age;
        bit ld;
    } wr_t;

    wr_t pend[$];
    int  m_rem;      // flush cycles still to come after this one
    bit  m_prev_haz;
    int  m_scnt;
    int  n_pass;
    int  n_checks;

    // Index into pend of the youngest visible write to rs, or -1.
    function automatic int youngest(input int rs, input bit en);
        int best = -1;
        if (!en || rs == 0) return -1;
        for (int i = 0; i < pend.size(); i++) begin
            if (pend[i].rd == rs && pend[i].age < LIM) begin
                if (best < 0 || pend[i].age < pend[best].age) best = i;
            end
        end
        return best;
    endfunction

    function automatic bit m_flushd();
        return jumping || (m_rem > 0);
    endfunction

    function automatic bit m_haz();
        int y1, y2;
        if (m_flushd()) return 1'b0;
        y1 = youngest(int'(id_rs1), id_rd_en[0]);
        y2 = youngest(int'(id_rs2), id_rd_en[1]);
`ifdef FORWARD_EN
        begin
            bit h = 1'b0;
            if (y1 >= 0 && pend[y1].age == 0 && pend[y1].ld) h = 1'b1;
            if (y2 >= 0 && pend[y2].age == 0 && pend[y2].ld) h = 1'b1;
            for (int i = 0; i < pend.size(); i++) begin
                if (pend[i].age >= 3 && pend[i].age < LIM &&
                    ((id_rd_en[0] && id_rs1 != 0 && pend[i].rd == int'(id_rs1)) ||
                     (id_rd_en[1] && id_rs2 != 0 && pend[i].rd == int'(id_rs2))))
                    h = 1'b1;
            end
            return h;
        end
`else
        return (y1 >= 0) || (y2 >= 0);
`endif
    endfunction

    function automatic logic [1:0] m_sel(input int rs, input bit en);
`ifdef FORWARD_EN
        int y = youngest(rs, en);
        if (y >= 0 && pend[y].age < 3) return 2'(pend[y].age + 1);
        return 2'd0;
`else
        return (rs > 99 && en) ? 2'd3 : 2'd0;
`endif
    endfunction

    function automatic logic [NR-1:0] m_busy();
        logic [NR-1:0] b = '0;
        foreach (pend[i]) b[pend[i].rd] = 1'b1;
        return b;
    endfunction

    function automatic logic [1:0] m_state();
        if (m_rem > 0) return 2'b10;
        if (m_prev_haz) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [63:0] exp_vec();
        bit h = m_haz();
        return 64'({m_sel(int'(id_rs1), id_rd_en[0]),
                    m_sel(int'(id_rs2), id_rd_en[1]),
                    h, h, m_flushd(), h, m_state(),
                    m_busy(), CW'(m_scnt)});
    endfunction

    function automatic logic [63:0] dut_vec();
        return 64'({fwd_sel_rs1, fwd_sel_rs2,
                    stall_F, stall_D, flush_D, flush_E, fsm_state,
                    busy_mask, stall_count});
    endfunction

    // Advance model with current inputs, then clock the DUT.
    task automatic tick();
        if (reset) begin
            pend.delete();
            m_rem = 0;
            m_prev_haz = 1'b0;
            m_scnt = 0;
        end else begin
            bit h = m_haz();
            bit fd = m_flushd();
            if (h && m_scnt < (1 << CW) - 1) m_scnt++;
            foreach (pend[i]) pend[i].age++;
            for (int i = pend.size() - 1; i >= 0; i--)
                if (pend[i].age >= PD) pend.delete(i);
            if (id_we && id_rd != 0 && !h && !fd)
                pend.push_front('{rd: int'(id_rd), age: 0, ld: id_is_load});
            if (jumping) m_rem = FC - 1;
            else if (m_rem > 0) m_rem--;
            m_prev_haz = h;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [1:0] en, input int rs1, input int rs2,
                          input bit we, input int rd, input bit ld,
                          input bit jmp);
        id_rd_en   = en;
        id_rs1     = AW'(rs1);
        id_rs2     = AW'(rs2);
        id_we      = we;
        id_rd      = AW'(rd);
        id_is_load = ld;
        jumping    = jmp;
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        set_in(2'b00, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        reset = 1'b0;
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1;
        set_in(2'b00, 0, 0, 1, 5, 0, 0);
        tick();
        tick();
        n_checks++;
        if (busy_mask !== '0)
            $display("FAIL reset_busy: got %h want 0", busy_mask);
        else n_pass++;
        n_checks++;
        if ({stall_F, stall_D, flush_D, flush_E} !== 4'b0)
            $display("FAIL reset_ctrl: got %b want 0000",
                     {stall_F, stall_D, flush_D, flush_E});
        else n_pass++;
        n_checks++;
        if (fsm_state !== 2'b00 || stall_count !== '0)
            $display("FAIL reset_state: got st=%b cnt=%0d want 00/0",
                     fsm_state, stall_count);
        else n_pass++;
        n_checks++;
        if ({fwd_sel_rs1, fwd_sel_rs2} !== 4'b0)
            $display("FAIL reset_fwd: got %b want 0000",
                     {fwd_sel_rs1, fwd_sel_rs2});
        else n_pass++;
        reset = 1'b0;
    endtask

    task automatic test_raw_stall();
        int nst = 0;
        bit saw = 1'b0;
        do_reset();
        set_in(2'b00, 0, 0, 1, 5, 0, 0);
        n_checks++;
        if (stall_D !== 1'b0)
            $display("FAIL raw_issue: got stall_D=%b want 0", stall_D);
        else n_pass++;
        tick();
        set_in(2'b01, 5, 0, 0, 0, 0, 0);
        n_checks++;
        if ({stall_F, stall_D, flush_E, flush_D} !== 4'b1110)
            $display("FAIL raw_ctrl: got %b want 1110",
                     {stall_F, stall_D, flush_E, flush_D});
        else n_pass++;
        for (int c = 0; c < 10 && stall_D; c++) begin
            if (fsm_state == 2'b01) saw = 1'b1;
            nst++;
            tick();
        end
        n_checks++;
        if (nst !== 2)
            $display("FAIL raw_len: got %0d stall cycles want 2", nst);
        else n_pass++;
        n_checks++;
        if (!saw || fsm_state !== 2'b01)
            $display("FAIL raw_state: got saw=%b st=%b want 1/01",
                     saw, fsm_state);
        else n_pass++;
        n_checks++;
        if (stall_count !== CW'(2))
            $display("FAIL raw_count: got %0d want 2", stall_count);
        else n_pass++;
        tick();
        n_checks++;
        if (fsm_state !== 2'b00)
            $display("FAIL raw_release: got st=%b want 00", fsm_state);
        else n_pass++;
    endtask

    task automatic test_x0();
        do_reset();
        set_in(2'b00, 0, 0, 1, 0, 0, 0);
        tick();
        set_in(2'b11, 0, 0, 0, 0, 0, 0);
        n_checks++;
        if (stall_D !== 1'b0 || busy_mask !== '0)
            $display("FAIL x0: got stall_D=%b busy=%h want 0/0",
                     stall_D, busy_mask);
        else n_pass++;
    endtask

    task automatic test_jump_flush();
        int nfl;
        do_reset();
        set_in(2'b00, 0, 0, 1, 5, 0, 0);
        tick();
        set_in(2'b01, 5, 0, 0, 0, 0, 1);
        n_checks++;
        if ({stall_D, flush_E, flush_D} !== 3'b001)
            $display("FAIL jump_prio: got %b want 001",
                     {stall_D, flush_E, flush_D});
        else n_pass++;
        nfl = 1;
        tick();
        set_in(2'b00, 0, 0, 0, 0, 0, 0);
        for (int c = 0; c < 10 && flush_D; c++) begin
            nfl++;
            tick();
        end
        n_checks++;
        if (nfl !== FC)
            $display("FAIL jump_len: got %0d want %0d", nfl, FC);
        else n_pass++;
        n_checks++;
        if (fsm_state !== 2'b00)
            $display("FAIL jump_end: got st=%b want 00", fsm_state);
        else n_pass++;
        set_in(2'b00, 0, 0, 0, 0, 0, 1);
        nfl = 1;
        tick();
        set_in(2'b00, 0, 0, 0, 0, 0, 1);
        n_checks++;
        if (flush_D !== 1'b1 || fsm_state !== 2'b10)
            $display("FAIL rejump_mid: got fd=%b st=%b want 1/10",
                     flush_D, fsm_state);
        else n_pass++;
        nfl++;
        tick();
        set_in(2'b00, 0, 0, 0, 0, 0, 0);
        for (int c = 0; c < 10 && flush_D; c++) begin
            nfl++;
            tick();
        end
        n_checks++;
        if (nfl !== FC + 1)
            $display("FAIL rejump_len: got %0d want %0d", nfl, FC + 1);
        else n_pass++;
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        set_in(2'b00, 0, 0, 1, 6, 0, 0);
        tick();
        set_in(2'b01, 6, 0, 0, 0, 0, 0);
        tick();
        n_checks++;
        if (fsm_state !== 2'b01 || stall_D !== 1'b1)
            $display("FAIL rst_pre: got st=%b stall_D=%b want 01/1",
                     fsm_state, stall_D);
        else n_pass++;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        n_checks++;
        if (fsm_state !== 2'b00 || stall_D !== 1'b0 || busy_mask !== '0)
            $display("FAIL rst_mid: got st=%b stall_D=%b busy=%h want 00/0/0",
                     fsm_state, stall_D, busy_mask);
        else n_pass++;
    endtask

`ifdef FORWARD_EN
    task automatic test_forward();
        do_reset();
        set_in(2'b00, 0, 0, 1, 7, 0, 0);
        tick();
        set_in(2'b01, 7, 0, 0, 0, 0, 0);
        n_checks++;
        if (stall_D !== 1'b0 || fwd_sel_rs1 !== 2'd1)
            $display("FAIL fwd_alu: got stall=%b sel=%0d want 0/1",
                     stall_D, fwd_sel_rs1);
        else n_pass++;
        tick();
        set_in(2'b00, 0, 0, 1, 7, 1, 0);
        tick();
        set_in(2'b01, 7, 0, 0, 0, 0, 0);
        n_checks++;
        if (stall_D !== 1'b1)
            $display("FAIL fwd_lu: got stall=%b want 1", stall_D);
        else n_pass++;
        tick();
        n_checks++;
        if (stall_D !== 1'b0 || fwd_sel_rs1 !== 2'd2)
            $display("FAIL fwd_lu_rel: got stall=%b sel=%0d want 0/2",
                     stall_D, fwd_sel_rs1);
        else n_pass++;
    endtask
`endif

    task automatic test_random();
        logic [63:0] e, g;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            reset = ($urandom_range(0, 99) == 0);
            set_in(2'($urandom_range(0, 3)),
                   int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                   1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                   1'($urandom_range(0, 1)), $urandom_range(0, 9) == 0);
            e = exp_vec();
            g = dut_vec();
            n_checks++;
            if (g !== e)
                $display("FAIL random[%0d]: got %h want %h", c, g, e);
            else n_pass++;
            tick();
        end
        reset = 1'b0;
    endtask

    initial begin
        n_pass = 0;
        n_checks = 0;
        m_rem = 0;
        m_prev_haz = 1'b0;
        m_scnt = 0;
        reset = 1'b1;
        set_in(2'b00, 0, 0, 0, 0, 0, 0);
        test_reset();
        test_raw_stall();
        test_x0();
        test_jump_flush();
        test_reset_mid_stall();
`ifdef FORWARD_EN
        test_forward();
`endif
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "timeout");
    end

endmodule
